stepper_pio_out: RTL and testbench
==================================

// Module: stepper_pio_out
// PURPOSE
//  Parametrised Avalon-MM output PIO; successor to the single-bit LED PIOs in the StepperMotorControl system.
//  Drives WIDTH output lines (LEDs, driver enables) through four register writes: DATA, atomic SET, CLEAR and TOGGLE.
//  Optional per-bit hardware blink, so software need not bit-bang status LEDs.
//  Sits on the Nios II data master; out_port goes to the top level.
// PARAMETERS
//  WIDTH        10     output line count, 1..32
//  RESET_VALUE  0      value loaded into DATA at reset, WIDTH bits
//  DIV_W        24     blink prescaler width; max half-period is 2**DIV_W-1 clk cycles
// PORTS
//  clk         in   1      system clock; all logic on rising edge
//  reset_n     in   1      synchronous, active-low reset
//  address     in   3      word address of register
//  chipselect  in   1      slave select
//  write_n     in   1      active-low write strobe
//  read_n      in   1      active-low read strobe
//  writedata   in   32     write data; bits above WIDTH/DIV_W ignored
//  readdata    out  32     registered read data, zero-extended
//  out_port    out  WIDTH  output lines
// BEHAVIOUR
//  Reset: sampled on clk edge while reset_n=0; reset_n is not in any sensitivity list.
//   Reset values: DATA=RESET_VALUE, BLINK_MASK=0, PERIOD=0, prescaler=0, phase=0, readdata=0, out_port=RESET_VALUE.
//   Reset overrides any write or read issued in the same cycle.
//  Write = chipselect & ~write_n. Register updates on the same edge; out_port changes 1 cycle after the write edge.
//  Register map (word addresses):
//   0 DATA    RW  write: DATA<=wd; read: DATA
//   1 SET     WO  DATA<=DATA|wd; reads 0
//   2 CLEAR   WO  DATA<=DATA&~wd; reads 0
//   3 TOGGLE  WO  DATA<=DATA^wd; reads 0
//   4 BLINK   RW  BLINK_MASK (WIDTH bits)
//   5 PERIOD  RW  half-period in clk cycles (DIV_W bits)
//   6,7       reserved; read 0, writes ignored
//  Read = chipselect & ~read_n. Read latency is fixed at 1: readdata is registered on the read edge and held until the next read.
//   A read and a write on the same edge return the pre-write value.
//  out_port = DATA ^ (BLINK_MASK & {WIDTH{phase}}), registered.
//  Prescaler, when PERIOD!=0:
//   counter increments each cycle.
//   When counter==PERIOD-1: counter<=0 and phase toggles.
//   Resulting square wave is 2*PERIOD cycles; PERIOD=1 toggles phase every cycle.
//  PERIOD==0: counter and phase held at 0; blinking bits show DATA.
//  Write to PERIOD (any value): counter<=0 and phase<=0 on the same edge.
//  Write to BLINK: phase is not disturbed. Masked bits start blinking in the current phase.
//  Simultaneous DATA/SET/CLEAR/TOGGLE write and phase toggle: both take effect on the same edge, with no lost update.
// CONFIGURATION
//  PIO_OUT_BLINK_EN defined: prescaler, BLINK and PERIOD registers are present as above.
//  PIO_OUT_BLINK_EN undefined:
//   addresses 4 and 5 read 0 and ignore writes.
//   phase is tied to 0, so out_port = DATA.
//   No prescaler flops are synthesised.
// STRUCTURE
//  Package stepper_pio_pkg: register address localparams (ADDR_DATA..ADDR_PERIOD) and the default DIV_W.
//  Sub-module stepper_pio_blink_div (DIV_W): inputs period and restart; output phase.
//   Instantiated only under PIO_OUT_BLINK_EN.
//  Top level holds the register file, read mux and output register.
// TESTING
//  1 Reset, WIDTH=10, RESET_VALUE=10'h155:
//    out_port=155h at first clk after reset_n; read addr0 -> 155h, one cycle after read.
//  2 Atomic writes:
//    write DATA=0F0h, SET=003h, CLEAR=030h, TOGGLE=300h -> out_port 0F0h,0F3h,0C3h,3C3h; each change one cycle after its write.
//  3 Blink: DATA=0, BLINK=001h, PERIOD=4:
//    out_port[0] high for 4 cycles, low for 4 cycles, repeating; other bits stay 0.
//    Write PERIOD=0 -> out_port[0]=0 and stays 0.
//  4 Collision: during blink, TOGGLE=001h on the phase-toggle edge.
//    Both effects apply, so out_port[0] is unchanged on that edge; DATA[0] reads 1.
//  5 Mid-blink reset: reset_n low 1 cycle while phase=1.
//    out_port=RESET_VALUE next cycle; BLINK and PERIOD read 0.
//  6 PIO_OUT_BLINK_EN undefined:
//    write BLINK=3FFh, PERIOD=2 -> both read 0; out_port tracks DATA only.

Source files
------------

// File: rtl/stepper_pio_pkg.sv
// Shared definitions for the stepper_pio output PIO.
// Holds the Avalon-MM word addresses of the register map and the
// default width of the blink prescaler.
package stepper_pio_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_CLEAR  = 3'd2;
    localparam logic [2:0] ADDR_TOGGLE = 3'd3;
    localparam logic [2:0] ADDR_BLINK  = 3'd4;
    localparam logic [2:0] ADDR_PERIOD = 3'd5;

    localparam int DEFAULT_DIV_W = 24;

endpackage

// File: rtl/stepper_pio_blink_div.sv
// Blink prescaler: produces a square-wave phase with a half-period of
// `period` clk cycles. A period of 0 parks the divider with phase low.
// Ports:
//   clk      in   system clock, rising edge
//   reset_n  in   synchronous active-low reset
//   period   in   half-period in clk cycles (DIV_W bits)
//   restart  in   clears counter and phase on this edge
//   phase    out  blink phase
module stepper_pio_blink_div #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] period,
    input  logic             restart,
    output logic             phase
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (restart || (period == '0)) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == (period - DIV_W'(1))) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/stepper_pio_out.sv
// Parametrised Avalon-MM output PIO driving WIDTH output lines.
// Registers: DATA (RW), SET/CLEAR/TOGGLE (atomic, WO), and, when the
// PIO_OUT_BLINK_EN macro is defined, BLINK mask and PERIOD for per-bit
// hardware blinking. Without the macro, addresses 4/5 read 0 and no
// prescaler is built.
// Ports:
//   clk         in   system clock, rising edge
//   reset_n     in   synchronous active-low reset
//   address     in   word address (3 bits)
//   chipselect  in   slave select
//   write_n     in   active-low write strobe
//   read_n      in   active-low read strobe
//   writedata   in   write data (32 bits)
//   readdata    out  registered read data, zero-extended, latency 1
//   out_port    out  registered output lines (WIDTH bits)
module stepper_pio_out
    import stepper_pio_pkg::*;
#(
    parameter int               WIDTH       = 10,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               DIV_W       = DEFAULT_DIV_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic             read_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic             wr_en, rd_en;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [31:0]      readdata_q, readdata_d;

    assign wr_en = chipselect & ~write_n;
    assign rd_en = chipselect & ~read_n;
    assign wd    = writedata[WIDTH-1:0];

    // Bits of writedata beyond the register widths are deliberately ignored.
    logic unused_wd;
    assign unused_wd = &{1'b0, writedata};

`ifdef PIO_OUT_BLINK_EN
    logic [WIDTH-1:0] blink_mask_q, blink_mask_d;
    logic [DIV_W-1:0] period_q, period_d;
    logic             restart;
    logic             phase;

    // Any PERIOD write restarts the divider so the new rate starts cleanly.
    assign restart = wr_en && (address == ADDR_PERIOD);

    always_comb begin
        blink_mask_d = blink_mask_q;
        period_d     = period_q;
        if (wr_en) begin
            if (address == ADDR_BLINK)  blink_mask_d = wd;
            if (address == ADDR_PERIOD) period_d     = writedata[DIV_W-1:0];
        end
    end

    stepper_pio_blink_div #(
        .DIV_W (DIV_W)
    ) u_blink_div (
        .clk     (clk),
        .reset_n (reset_n),
        .period  (period_q),
        .restart (restart),
        .phase   (phase)
    );
`else
    logic [DIV_W-1:0] unused_period;
    assign unused_period = writedata[DIV_W-1:0];
`endif

    always_comb begin
        data_d = data_q;
        if (wr_en) begin
            case (address)
                ADDR_DATA:   data_d = wd;
                ADDR_SET:    data_d = data_q | wd;
                ADDR_CLEAR:  data_d = data_q & ~wd;
                ADDR_TOGGLE: data_d = data_q ^ wd;
                default:     data_d = data_q;
            endcase
        end
    end

    // Reads sample the current register values, so a simultaneous write
    // returns the pre-write contents.
    always_comb begin
        readdata_d = readdata_q;
        if (rd_en) begin
            case (address)
                ADDR_DATA:   readdata_d = 32'(data_q);
`ifdef PIO_OUT_BLINK_EN
                ADDR_BLINK:  readdata_d = 32'(blink_mask_q);
                ADDR_PERIOD: readdata_d = 32'(period_q);
`endif
                default:     readdata_d = '0;
            endcase
        end
    end

    // Output uses the registered DATA and phase, so a data write and a phase
    // toggle on the same edge both show up together one cycle later.
    always_comb begin
`ifdef PIO_OUT_BLINK_EN
        out_d = data_q ^ (blink_mask_q & {WIDTH{phase}});
`else
        out_d = data_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q       <= RESET_VALUE;
            out_q        <= RESET_VALUE;
            readdata_q   <= '0;
`ifdef PIO_OUT_BLINK_EN
            blink_mask_q <= '0;
            period_q     <= '0;
`endif
        end else begin
            data_q       <= data_d;
            out_q        <= out_d;
            readdata_q   <= readdata_d;
`ifdef PIO_OUT_BLINK_EN
            blink_mask_q <= blink_mask_d;
            period_q     <= period_d;
`endif
        end
    end

    assign readdata = readdata_q;
    assign out_port = out_q;

endmodule

// File: tb/tb_stepper_pio_out.sv
module tb_stepper_pio_out;
    import stepper_pio_pkg::*;

    localparam int               WIDTH = 10;
    localparam logic [WIDTH-1:0] RV    = 10'h155;

    logic             clk        = 1'b0;
    logic             reset_n    = 1'b0;
    logic [2:0]       address    = '0;
    logic             chipselect = 1'b0;
    logic             write_n    = 1'b1;
    logic             read_n     = 1'b1;
    logic [31:0]      writedata  = '0;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;

    stepper_pio_out #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RV),
        .DIV_W       (24)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .read_n     (read_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        bit          is_read;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   passed = 0;
    int   total  = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int due, input bit is_read, input logic [31:0] v, input string nm);
        exp_t e;
        e.due = due; e.is_read = is_read; e.val = v; e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic push_out(input int due, input logic [31:0] v, input string nm);
        push_exp(due, 1'b0, v, nm);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        step();
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    task automatic bus_read(input logic [2:0] a, input logic [31:0] v, input string nm);
        push_exp(cyc + 1, 1'b1, v, nm);
        chipselect = 1'b1; read_n = 1'b0; address = a;
        step();
        chipselect = 1'b0; read_n = 1'b1;
    endtask

    task automatic idle_to(input int t);
        while (cyc < t) step();
    endtask

    // Monitor: compares every expectation due in the current cycle.
    always @(negedge clk) begin
        int          i;
        logic [31:0] act;
        i = 0;
        while (i < exp_q.size()) begin
            if (exp_q[i].due == cyc) begin
                act = exp_q[i].is_read ? readdata : 32'(out_port);
                total++;
                if (act === exp_q[i].val) passed++;
                else $display("FAIL %s: cycle %0d got %h expected %h",
                              exp_q[i].name, cyc, act, exp_q[i].val);
                exp_q.delete(i);
            end else if (exp_q[i].due < cyc) begin
                total++;
                $display("FAIL %s: not observed, due cycle %0d", exp_q[i].name, exp_q[i].due);
                exp_q.delete(i);
            end else begin
                i++;
            end
        end
    end

    initial begin
        int n, k, m, p, r;

        // Reset, with a DATA write held during reset that must be dropped.
        repeat (3) step();
        k = cyc;
        chipselect = 1'b1; write_n = 1'b0; address = ADDR_DATA; writedata = 32'h3FF;
        push_out(k + 1, 32'h155, "rst_out");
        push_out(k + 2, 32'h155, "rst_write_override");
        push_out(k + 3, 32'h155, "rst_out_hold");
        step();
        reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        step();
        bus_read(ADDR_DATA, 32'h155, "rst_read_data");
        r = cyc;
        push_exp(r + 1, 1'b1, 32'h155, "readdata_hold");

        // Atomic writes.
        n = cyc;
        push_out(n + 2, 32'h0F0, "wr_data");
        push_out(n + 3, 32'h0F3, "wr_set");
        push_out(n + 4, 32'h0C3, "wr_clear");
        push_out(n + 5, 32'h3C3, "wr_toggle");
        bus_write(ADDR_DATA,   32'h0F0);
        bus_write(ADDR_SET,    32'h003);
        bus_write(ADDR_CLEAR,  32'h030);
        bus_write(ADDR_TOGGLE, 32'h300);
        bus_read(ADDR_DATA,   32'h3C3, "rd_data");
        bus_read(ADDR_SET,    32'h0,   "rd_set_zero");
        bus_read(ADDR_CLEAR,  32'h0,   "rd_clear_zero");
        bus_read(ADDR_TOGGLE, 32'h0,   "rd_toggle_zero");
        bus_read(3'd6,        32'h0,   "rd_rsvd6");
        bus_read(3'd7,        32'h0,   "rd_rsvd7");
        bus_write(3'd6, 32'h3FF);
        bus_write(3'd7, 32'h000);
        bus_read(ADDR_DATA, 32'h3C3, "rsvd_write_ignored");

        // Upper writedata bits ignored; readback zero-extended.
        bus_write(ADDR_DATA, 32'hFFFF_FC0A);
        bus_read(ADDR_DATA, 32'h00A, "rd_zero_ext");

        // Read and write on the same edge returns the old value.
        m = cyc;
        push_exp(m + 1, 1'b1, 32'h00A, "rd_during_wr");
        chipselect = 1'b1; write_n = 1'b0; read_n = 1'b0; address = ADDR_DATA; writedata = 32'h111;
        step();
        chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1; writedata = '0;
        bus_read(ADDR_DATA, 32'h111, "rd_after_wr");
        push_out(cyc, 32'h111, "out_after_rdw");

`ifdef PIO_OUT_BLINK_EN
        // Blink bit 0 with half-period 4.
        n = cyc;
        bus_write(ADDR_DATA,   32'h000);
        bus_write(ADDR_BLINK,  32'h001);
        bus_write(ADDR_PERIOD, 32'd4);
        for (int c = n + 4; c < n + 22; c++)
            push_out(c, 32'(((c - n - 4) / 4) % 2), "blink_wave");
        bus_read(ADDR_BLINK,  32'h001, "rd_blink");
        bus_read(ADDR_PERIOD, 32'd4,   "rd_period");
        idle_to(n + 22);

        // TOGGLE lands on a phase-toggle edge: bit 0 must not move there.
        for (int c = n + 22; c < n + 30; c++) begin
            if (c < n + 24) push_out(c, 32'(((c - n - 4) / 4) % 2), "collide_before");
            else            push_out(c, 32'(1 - ((c - n - 4) / 4) % 2), "collide_after");
        end
        bus_write(ADDR_TOGGLE, 32'h001);
        bus_read(ADDR_DATA, 32'h001, "collide_data");
        idle_to(n + 30);

        // PERIOD=0 parks the blinker.
        m = cyc;
        bus_write(ADDR_DATA,   32'h000);
        bus_write(ADDR_PERIOD, 32'd0);
        for (int c = m + 3; c < m + 11; c++) push_out(c, 32'h0, "period0_out");
        bus_read(ADDR_PERIOD, 32'd0, "rd_period0");
        idle_to(m + 11);

        // Reset while phase is high.
        p = cyc;
        bus_write(ADDR_PERIOD, 32'd4);
        idle_to(p + 6);
        push_out(p + 6, 32'h001, "pre_reset_phase1");
        push_out(p + 7, 32'h155, "mid_reset_out");
        push_out(p + 8, 32'h155, "post_reset_out");
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        bus_read(ADDR_BLINK,  32'h0,   "rst_blink");
        bus_read(ADDR_PERIOD, 32'h0,   "rst_period");
        bus_read(ADDR_DATA,   32'h155, "rst_data2");
`else
        // Blink disabled: BLINK/PERIOD are absent, out_port follows DATA.
        bus_write(ADDR_BLINK,  32'h3FF);
        bus_write(ADDR_PERIOD, 32'd2);
        bus_read(ADDR_BLINK,  32'h0, "noblink_rd_blink");
        bus_read(ADDR_PERIOD, 32'h0, "noblink_rd_period");
        n = cyc;
        for (int c = n; c < n + 8; c++) push_out(c, 32'h111, "noblink_out");
        idle_to(n + 8);
        n = cyc;
        for (int c = n + 2; c < n + 6; c++) push_out(c, 32'h110, "noblink_toggle");
        bus_write(ADDR_TOGGLE, 32'h001);
        idle_to(n + 6);
`endif

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        foreach (exp_q[j]) begin
            total++;
            $display("FAIL %s: expectation never checked (due %0d)", exp_q[j].name, exp_q[j].due);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
